set_compare_iter: RTL
=====================

Name: set_compare_iter

Overview:
- Parametrised, multi-cycle successor to the single-function combinational set units (seq/sne/slt/sgt/sle/sge).
- One block evaluates all six set conditions, signed or unsigned, on WIDTH-bit operands.
- Computes a - b with a CHUNK-bit ripple slice per cycle, so one narrow adder serves the ALU set path.
- Valid/ready handshake on both sides, so it can sit behind the ALU operand mux and stall the pipeline.

Parameters:
WIDTH, 32, operand and result width in bits
CHUNK, 8, bits subtracted per cycle; must divide WIDTH; N = WIDTH/CHUNK cycles per op

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands and op presented
in_ready  output  1  block can accept an op
a  input  WIDTH  operand A, bit 0 = LSB
b  input  WIDTH  operand B, bit 0 = LSB
op  input  3  0 SEQ, 1 SNE, 2 SLT, 3 SGT, 4 SLE, 5 SGE, 6/7 reserved
is_signed  input  1  1 = two's-complement compare, 0 = unsigned
out_valid  output  1  set result available
out_ready  input  1  consumer takes result
set  output  WIDTH  result, 1 (zero-extended) if condition true, else 0

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (sampled on a rising edge with reset=1, any state):
  - go to IDLE, in_ready=1, out_valid=0, set=0.
  - An in-flight op is discarded; no partial result is ever presented.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: capture a, b, op and is_signed; load carry=1 and zero=1; chunk count=0; go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0; in_valid and input changes are ignored.
  - Each edge processes slice k (bits k*CHUNK..k*CHUNK+CHUNK-1, LSB slice first):
    - sum = a_slice + ~b_slice + carry.
    - carry = carry-out of the slice.
    - zero = zero AND (sum slice == 0).
  - After the N-th slice edge, go to DONE with the result registered.
  - out_valid rises exactly N edges after the accepting edge (CHUNK=WIDTH gives 1 edge).
- Flags, computed from the final carry c and zero z:
  - eq = z.
  - Unsigned: lt = ~c.
  - Signed: lt = (a[WIDTH-1] & ~b[WIDTH-1]) | (~(a[WIDTH-1] ^ b[WIDTH-1]) & ~c).
- Result by op:
  - SEQ = eq; SNE = ~eq; SLT = lt; SGE = ~lt.
  - SLE = lt | eq; SGT = ~(lt | eq).
  - Reserved ops give set=0, with normal latency and handshake.
- set bits [WIDTH-1:1] are always 0.
- DONE:
  - out_valid=1, in_ready=0.
  - set holds stable for as long as out_ready=0 (unbounded).
  - On an edge with out_ready=1: go to IDLE, out_valid=0; set keeps its last value.
  - No same-cycle accept of a new op.
  - Minimum issue interval is N+2 edges.
- reset overrides every other input on the same edge.
- Operand capture is registered; changing a/b during BUSY does not affect the result.

Test Plan:
1. WIDTH=32, CHUNK=8: SEQ a=5, b=5 -> out_valid exactly 4 edges after accept, set=1; SNE on the same operands -> set=0.
2. SLT a=1, b=0xFFFFFFFF: unsigned -> set=1; signed -> set=0. SGT, signed, same operands -> set=1.
3. a=b=0x80000000, signed and unsigned: SLE=1, SGE=1, SLT=0, SGT=0. Then a=0x7FFFFFFF, b=0x80000000, signed SGT -> 1; unsigned SGT -> 0.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid while toggling in_valid, a and b -> set constant, in_ready=0, no new op accepted. Raise out_ready -> in_ready=1 on the next cycle; the next op returns the correct result.
5. Assert reset 2 edges into BUSY -> next cycle out_valid=0, set=0, in_ready=1. SLT a=3, b=7 issued afterwards -> set=1.
6. WIDTH=16, CHUNK=16 (N=1): op=6 -> set=0 after 1 edge. SGE a=0, b=0 -> set=1.

Source files
------------

// File: rtl/set_compare_iter.sv
// Multi-cycle set-compare unit: evaluates SEQ/SNE/SLT/SGT/SLE/SGE on WIDTH-bit
// operands by rippling a - b through a CHUNK-bit slice per cycle.
module set_compare_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] set
);

    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    localparam logic [2:0] OP_SEQ = 3'd0;
    localparam logic [2:0] OP_SNE = 3'd1;
    localparam logic [2:0] OP_SLT = 3'd2;
    localparam logic [2:0] OP_SGT = 3'd3;
    localparam logic [2:0] OP_SLE = 3'd4;
    localparam logic [2:0] OP_SGE = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    // Operands shift right one slice per cycle so the adder always sees bits [CHUNK-1:0].
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_msb;
    logic             r_b_msb;
    logic [2:0]       r_op;
    logic             r_signed;
    logic             r_carry;
    logic             r_zero;
    logic [CNT_W-1:0] r_cnt;
    logic             r_set_bit;

    logic             w_accept;
    logic             w_slice;
    logic             w_last_slice;
    logic [CHUNK:0]   w_sum;
    logic             w_carry_next;
    logic             w_zero_next;
    logic             w_eq;
    logic             w_lt;
    logic             w_result;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: every output of this block is given a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == LAST_SLICE) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign w_accept     = (r_state == S_IDLE) && in_valid;
    assign w_slice      = (r_state == S_BUSY);
    assign w_last_slice = w_slice && (r_cnt == LAST_SLICE);

    // a - b as a + ~b + carry, carry seeded to 1 on accept.
    assign w_sum        = {1'b0, r_a[CHUNK-1:0]} + {1'b0, ~r_b[CHUNK-1:0]} + (CHUNK+1)'(r_carry);
    assign w_carry_next = w_sum[CHUNK];
    assign w_zero_next  = r_zero & (w_sum[CHUNK-1:0] == '0);

    always_comb begin
        w_eq = w_zero_next;
        if (r_signed) begin
            w_lt = (r_a_msb & ~r_b_msb) | (~(r_a_msb ^ r_b_msb) & ~w_carry_next);
        end else begin
            w_lt = ~w_carry_next;
        end
        case (r_op)
            OP_SEQ:  w_result = w_eq;
            OP_SNE:  w_result = ~w_eq;
            OP_SLT:  w_result = w_lt;
            OP_SGT:  w_result = ~(w_lt | w_eq);
            OP_SLE:  w_result = w_lt | w_eq;
            OP_SGE:  w_result = ~w_lt;
            default: w_result = 1'b0;
        endcase
    end

    // NOTE: the datapath is cleared by reset as well, so an op cut short by reset
    // can never leak a partial carry/zero or result into a later transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
            r_op      <= '0;
            r_signed  <= 1'b0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_cnt     <= '0;
            r_set_bit <= 1'b0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_a_msb  <= a[WIDTH-1];
            r_b_msb  <= b[WIDTH-1];
            r_op     <= op;
            r_signed <= is_signed;
            r_carry  <= 1'b1;
            r_zero   <= 1'b1;
            r_cnt    <= '0;
        end else if (w_slice) begin
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_carry_next;
            r_zero  <= w_zero_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last_slice) begin
                r_set_bit <= w_result;
            end
        end
    end

    assign set = {{(WIDTH-1){1'b0}}, r_set_bit};

endmodule
